// File: rtl/wb_stage_pkg.sv
// rtl/wb_stage_pkg.sv - shared constants, FSM states and helpers for the write-back stage
package wb_stage_pkg;

  localparam logic [31:0] WB_RESET_PC = 32'hbfc00000;

  localparam logic [5:0] OP_LB  = 6'h20;
  localparam logic [5:0] OP_LH  = 6'h21;
  localparam logic [5:0] OP_LWL = 6'h22;
  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_LBU = 6'h24;
  localparam logic [5:0] OP_LHU = 6'h25;
  localparam logic [5:0] OP_LWR = 6'h26;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } wb_state_t;

  function automatic logic is_load_op(input logic [5:0] op);
    logic r;
    case (op)
      OP_LB, OP_LH, OP_LWL, OP_LW, OP_LBU, OP_LHU, OP_LWR: r = 1'b1;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/wb_stage_load_align.sv
// rtl/wb_stage_load_align.sv - combinational load data alignment, extension and LWL/LWR merge
module wb_stage_load_align
  import wb_stage_pkg::*;
(
  input  logic [5:0]  op,
  input  logic [1:0]  k,
  input  logic [31:0] w,
  input  logic [31:0] rt,
  output logic [31:0] wdata,
  output logic [3:0]  we
);

  logic [1:0]  kk;
  logic [4:0]  shl;
  logic [4:0]  shr;
  logic [31:0] w_shr;
  logic [7:0]  b;
  logic [15:0] h;

  always_comb begin
    kk    = 2'd3 - k;
    shl   = {kk, 3'b000};
    shr   = {k, 3'b000};
    w_shr = w >> shr;
    b     = w_shr[7:0];
    h     = k[1] ? w[31:16] : w[15:0];
    wdata = w;
    we    = 4'b1111;
    case (op)
      OP_LB:  wdata = {{24{b[7]}}, b};
      OP_LBU: wdata = {24'h0, b};
      OP_LH:  wdata = {{16{h[15]}}, h};
      OP_LHU: wdata = {16'h0, h};
      OP_LWL: begin
        wdata = (w << shl) | (rt & ~(32'hffffffff << shl));
        we    = 4'b1111 << kk;
      end
      OP_LWR: begin
        wdata = w_shr | (rt & ~(32'hffffffff >> shr));
        we    = 4'b1111 >> k;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// rtl/wb_stage.sv - MIPS write-back stage with load response wait; WB_DEBUG_TRACE_EN adds debug trace ports
module wb_stage
  import wb_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = WB_RESET_PC,
  parameter int          EARLY_BUF = 1
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        mem_valid,
  input  logic [31:0] mem_pc,
  input  logic [31:0] mem_inst,
  input  logic [4:0]  mem_dest,
  input  logic        mem_memtoreg,
  input  logic [31:0] mem_result,
  input  logic [31:0] mem_reg_rt,
  input  logic [31:0] mem_paddr,
  input  logic [31:0] data_rdata,
  input  logic        data_data_ok,
  output logic        wb_stall,
  output logic [3:0]  rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic [4:0]  wb_fwd_dest,
  output logic [31:0] wb_fwd_data
`ifdef WB_DEBUG_TRACE_EN
  ,
  output logic [31:0] debug_wb_pc,
  output logic [3:0]  debug_wb_rf_wen,
  output logic [4:0]  debug_wb_rf_wnum,
  output logic [31:0] debug_wb_rf_wdata
`endif
);

  wb_state_t   state, state_n;
  logic [31:0] pc_q, result_q, rt_q, paddr_q;
  logic [5:0]  op_q;
  logic [4:0]  dest_q;
  logic        m2r_q, valid_q;
  logic [31:0] rbuf, ebuf;
  logic        early_valid, early_avail;
  logic        cap_load, slot_load;
  logic [31:0] al_wdata;
  logic [3:0]  al_we;
  logic [3:0]  base_we;
  logic        unused_bits;

  assign unused_bits = ^{mem_inst[25:0], pc_q, paddr_q[31:2]};
  assign cap_load    = mem_valid && !wb_stall && mem_memtoreg && is_load_op(mem_inst[31:26]);
  assign slot_load   = m2r_q && is_load_op(op_q);
  assign early_avail = (EARLY_BUF != 0) && early_valid;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      pc_q     <= RESET_PC;
      op_q     <= 6'h0;
      dest_q   <= 5'h0;
      m2r_q    <= 1'b0;
      result_q <= 32'h0;
      rt_q     <= 32'h0;
      paddr_q  <= 32'h0;
      valid_q  <= 1'b0;
    end else if (!wb_stall) begin
      valid_q <= mem_valid;
      if (mem_valid) begin
        pc_q     <= mem_pc;
        op_q     <= mem_inst[31:26];
        dest_q   <= mem_dest;
        m2r_q    <= mem_memtoreg;
        result_q <= mem_result;
        rt_q     <= mem_reg_rt;
        paddr_q  <= mem_paddr;
      end else begin
        dest_q <= 5'h0;
        m2r_q  <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) state <= S_IDLE;
    else         state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE, S_DONE: begin
        if (cap_load) state_n = (early_avail || data_data_ok) ? S_DONE : S_WAIT;
        else          state_n = S_IDLE;
      end
      S_WAIT:  if (data_data_ok) state_n = S_DONE;
      default: state_n = S_IDLE;
    endcase
  end

  // A buffered early response is older than a same-cycle one, so it is consumed first.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      rbuf        <= 32'h0;
      ebuf        <= 32'h0;
      early_valid <= 1'b0;
    end else begin
      if (state == S_WAIT && data_data_ok)
        rbuf <= data_rdata;
      else if (cap_load)
        rbuf <= early_avail ? ebuf : data_rdata;
      if (EARLY_BUF != 0) begin
        if (cap_load && early_valid) begin
          early_valid <= data_data_ok;
          if (data_data_ok) ebuf <= data_rdata;
        end else if (data_data_ok && state != S_WAIT && !cap_load) begin
          early_valid <= 1'b1;
          ebuf        <= data_rdata;
        end
      end
    end
  end

  wb_stage_load_align u_align (
    .op    (op_q),
    .k     (paddr_q[1:0]),
    .w     (rbuf),
    .rt    (rt_q),
    .wdata (al_wdata),
    .we    (al_we)
  );

  assign base_we     = slot_load ? ((state == S_DONE) ? al_we : 4'h0) : 4'hf;
  assign wb_stall    = (state == S_WAIT);
  assign rf_we       = (!valid_q || dest_q == 5'h0 || wb_stall) ? 4'h0 : base_we;
  assign rf_waddr    = dest_q;
  assign rf_wdata    = slot_load ? al_wdata : result_q;
  assign wb_fwd_dest = (rf_we != 4'h0) ? dest_q : 5'h0;
  assign wb_fwd_data = rf_wdata;

`ifdef WB_DEBUG_TRACE_EN
  assign debug_wb_pc       = pc_q;
  assign debug_wb_rf_wen   = rf_we;
  assign debug_wb_rf_wnum  = dest_q;
  assign debug_wb_rf_wdata = rf_wdata;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// tb/tb_wb_stage.sv - scoreboard bench for wb_stage
module tb_wb_stage;

  logic        clk = 1'b0;
  logic        resetn;
  logic        mem_valid;
  logic [31:0] mem_pc, mem_inst, mem_result, mem_reg_rt, mem_paddr;
  logic [4:0]  mem_dest;
  logic        mem_memtoreg;
  logic [31:0] data_rdata;
  logic        data_data_ok;
  logic        wb_stall;
  logic [3:0]  rf_we;
  logic [4:0]  rf_waddr, wb_fwd_dest;
  logic [31:0] rf_wdata, wb_fwd_data;
`ifdef WB_DEBUG_TRACE_EN
  logic [31:0] debug_wb_pc, debug_wb_rf_wdata;
  logic [3:0]  debug_wb_rf_wen;
  logic [4:0]  debug_wb_rf_wnum;
`endif

  always #5 clk = ~clk;

  wb_stage dut (
    .clk          (clk),
    .resetn       (resetn),
    .mem_valid    (mem_valid),
    .mem_pc       (mem_pc),
    .mem_inst     (mem_inst),
    .mem_dest     (mem_dest),
    .mem_memtoreg (mem_memtoreg),
    .mem_result   (mem_result),
    .mem_reg_rt   (mem_reg_rt),
    .mem_paddr    (mem_paddr),
    .data_rdata   (data_rdata),
    .data_data_ok (data_data_ok),
    .wb_stall     (wb_stall),
    .rf_we        (rf_we),
    .rf_waddr     (rf_waddr),
    .rf_wdata     (rf_wdata),
    .wb_fwd_dest  (wb_fwd_dest),
    .wb_fwd_data  (wb_fwd_data)
`ifdef WB_DEBUG_TRACE_EN
    ,
    .debug_wb_pc       (debug_wb_pc),
    .debug_wb_rf_wen   (debug_wb_rf_wen),
    .debug_wb_rf_wnum  (debug_wb_rf_wnum),
    .debug_wb_rf_wdata (debug_wb_rf_wdata)
`endif
  );

  typedef struct {
    logic [3:0]  we;
    logic [4:0]  addr;
    logic [31:0] data;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   stall_cnt = 0;
  int   lat;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (resetn === 1'b1) begin
      if (wb_stall) stall_cnt++;
      if (rf_we != 4'h0) begin
        if (sb.size() == 0) begin
          check("unexpected_we", {28'h0, rf_we}, 32'h0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("rf_we", {28'h0, rf_we}, {28'h0, e.we});
          check("rf_waddr", {27'h0, rf_waddr}, {27'h0, e.addr});
          check("rf_wdata", rf_wdata, e.data);
          check("fwd_dest", {27'h0, wb_fwd_dest}, {27'h0, e.addr});
          check("fwd_data", wb_fwd_data, e.data);
        end
      end else begin
        check("fwd_dest_idle", {27'h0, wb_fwd_dest}, 32'h0);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_mem(input logic v, input logic [5:0] op, input logic [4:0] d, input logic m2r,
                         input logic [31:0] res, input logic [31:0] rt, input logic [31:0] pa);
    mem_valid    = v;
    mem_pc       = 32'h8000_1000 + {27'h0, d};
    mem_inst     = {op, 26'h0123456};
    mem_dest     = d;
    mem_memtoreg = m2r;
    mem_result   = res;
    mem_reg_rt   = rt;
    mem_paddr    = pa;
  endtask

  task automatic push(input logic [3:0] we, input logic [4:0] addr, input logic [31:0] data);
    exp_t e;
    e.we = we; e.addr = addr; e.data = data;
    sb.push_back(e);
  endtask

  task automatic drain(input string tag, output int n);
    n = 0;
    while (sb.size() != 0 && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    check({tag, "_drain"}, sb.size(), 32'h0);
    tick();
  endtask

  // Load whose response arrives in the capture cycle: must write in the first WB cycle, no stall.
  task automatic load_now(input string tag, input logic [5:0] op, input logic [1:0] k, input logic [4:0] d,
                          input logic [31:0] w, input logic [31:0] rt,
                          input logic [31:0] exp_d, input logic [3:0] exp_we);
    if (d != 5'h0) push(exp_we, d, exp_d);
    set_mem(1'b1, op, d, 1'b1, 32'h5555_5555, rt, {28'h0004000, 2'b00, k});
    data_data_ok = 1'b1;
    data_rdata   = w;
    stall_cnt    = 0;
    tick();
    mem_valid    = 1'b0;
    data_data_ok = 1'b0;
    if (d != 5'h0) begin
      drain(tag, lat);
      check({tag, "_lat"}, lat, 32'd1);
    end else begin
      tick();
      tick();
    end
    check({tag, "_stall"}, stall_cnt, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    resetn = 1'b0;
    data_rdata = 32'h0;
    data_data_ok = 1'b0;
    set_mem(1'b0, 6'h0, 5'h0, 1'b0, 32'h0, 32'h0, 32'h0);
    tick();
    tick();
    @(negedge clk);
    check("rst_stall", {31'h0, wb_stall}, 32'h0);
    check("rst_we", {28'h0, rf_we}, 32'h0);
    check("rst_waddr", {27'h0, rf_waddr}, 32'h0);
    check("rst_wdata", rf_wdata, 32'h0);
    check("rst_fdest", {27'h0, wb_fwd_dest}, 32'h0);
    check("rst_fdata", wb_fwd_data, 32'h0);
    tick();
    resetn = 1'b1;
    tick();

    // ADDU
    push(4'hf, 5'd5, 32'h12345678);
    set_mem(1'b1, 6'h00, 5'd5, 1'b0, 32'h12345678, 32'h0, 32'h0);
    stall_cnt = 0;
    tick();
    mem_valid = 1'b0;
    drain("addu", lat);
    check("addu_lat", lat, 32'd1);
    check("addu_stall", stall_cnt, 32'd0);

    // LB k=3, response two cycles after the capture cycle
    push(4'hf, 5'd6, 32'hFFFFFF80);
    set_mem(1'b1, 6'h20, 5'd6, 1'b1, 32'h0, 32'h0, 32'h0000_1003);
    stall_cnt = 0;
    tick();
    mem_valid = 1'b0;
    tick();
    data_data_ok = 1'b1;
    data_rdata   = 32'h80FF1234;
    tick();
    data_data_ok = 1'b0;
    drain("lb_wait", lat);
    check("lb_wait_lat", lat, 32'd1);
    check("lb_wait_stall", stall_cnt, 32'd2);

    load_now("lhu_k2", 6'h25, 2'd2, 5'd10, 32'h80FF1234, 32'h0, 32'h000080FF, 4'hf);
    load_now("lwl_k1", 6'h22, 2'd1, 5'd11, 32'h44332211, 32'hAABBCCDD, 32'h2211CCDD, 4'b1100);
    load_now("lwr_k2", 6'h26, 2'd2, 5'd12, 32'h44332211, 32'hAABBCCDD, 32'hAABB4433, 4'b0011);
    load_now("lwl_k0", 6'h22, 2'd0, 5'd13, 32'h44332211, 32'hAABBCCDD, 32'h11BBCCDD, 4'b1000);
    load_now("lwl_k3", 6'h22, 2'd3, 5'd14, 32'h44332211, 32'hAABBCCDD, 32'h44332211, 4'b1111);
    load_now("lwr_k0", 6'h26, 2'd0, 5'd15, 32'h44332211, 32'hAABBCCDD, 32'h44332211, 4'b1111);
    load_now("lwr_k3", 6'h26, 2'd3, 5'd16, 32'h44332211, 32'hAABBCCDD, 32'hAABBCC44, 4'b0001);
    load_now("lb_k0", 6'h20, 2'd0, 5'd17, 32'h80FF1234, 32'h0, 32'h00000034, 4'hf);
    load_now("lb_k2", 6'h20, 2'd2, 5'd18, 32'h80FF1234, 32'h0, 32'hFFFFFFFF, 4'hf);
    load_now("lbu_k3", 6'h24, 2'd3, 5'd19, 32'h80FF1234, 32'h0, 32'h00000080, 4'hf);
    load_now("lh_k2", 6'h21, 2'd2, 5'd20, 32'h80FF1234, 32'h0, 32'hFFFF80FF, 4'hf);
    load_now("lh_k0", 6'h21, 2'd0, 5'd21, 32'h80FF1234, 32'h0, 32'h00001234, 4'hf);
    load_now("lw", 6'h23, 2'd0, 5'd22, 32'h80FF1234, 32'h0, 32'h80FF1234, 4'hf);
    load_now("lw_d0", 6'h23, 2'd0, 5'd0, 32'h80FF1234, 32'h0, 32'h0, 4'h0);

    // Early response one cycle before the LW enters
    data_data_ok = 1'b1;
    data_rdata   = 32'hCAFEBABE;
    tick();
    data_data_ok = 1'b0;
    data_rdata   = 32'h0;
    push(4'hf, 5'd7, 32'hCAFEBABE);
    set_mem(1'b1, 6'h23, 5'd7, 1'b1, 32'h0, 32'h0, 32'h0000_2000);
    stall_cnt = 0;
    tick();
    mem_valid = 1'b0;
    drain("early_lw", lat);
    check("early_lw_lat", lat, 32'd1);
    check("early_lw_stall", stall_cnt, 32'd0);

    // Second load parks in WAIT, then reset drops it
    set_mem(1'b1, 6'h23, 5'd8, 1'b1, 32'h0, 32'h0, 32'h0000_2004);
    tick();
    mem_valid = 1'b0;
    @(negedge clk);
    check("wait_stall", {31'h0, wb_stall}, 32'h1);
    #1;
    resetn = 1'b0;
    tick();
    tick();
    @(negedge clk);
    check("mid_rst_stall", {31'h0, wb_stall}, 32'h0);
    check("mid_rst_we", {28'h0, rf_we}, 32'h0);
    check("mid_rst_waddr", {27'h0, rf_waddr}, 32'h0);
    check("mid_rst_wdata", rf_wdata, 32'h0);
    check("mid_rst_fdest", {27'h0, wb_fwd_dest}, 32'h0);
    check("mid_rst_fdata", wb_fwd_data, 32'h0);
    tick();
    resetn = 1'b1;
    tick();

    // After reset a load must wait for its own response
    push(4'hf, 5'd9, 32'hDEADBEEF);
    set_mem(1'b1, 6'h23, 5'd9, 1'b1, 32'h0, 32'h0, 32'h0000_3000);
    tick();
    mem_valid = 1'b0;
    @(negedge clk);
    check("post_rst_stall", {31'h0, wb_stall}, 32'h1);
    #1;
    data_data_ok = 1'b1;
    data_rdata   = 32'hDEADBEEF;
    tick();
    data_data_ok = 1'b0;
    drain("post_rst", lat);
    check("post_rst_lat", lat, 32'd1);

    tick();
    tick();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
